// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a 64x8 simple dual-port RAM: independent round-robin
// read/write arbitration plus a two-stage read response path. Optional: RAM_ARB_BYPASS_EN.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic              req_we_0,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  logic wr_req_0, wr_req_1, rd_req_0, rd_req_1;
  logic wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1;
  logic wr_ptr, rd_ptr;
  logic s1_valid, s1_id;
  logic [DATA_W-1:0] rsp_data;

  // The pointer names the requester that wins a tie; grants are masked during reset.
  always_comb begin
    wr_req_0 = req_valid_0 & req_we_0;
    wr_req_1 = req_valid_1 & req_we_1;
    rd_req_0 = req_valid_0 & ~req_we_0;
    rd_req_1 = req_valid_1 & ~req_we_1;
    wr_gnt_0 = ~rst & wr_req_0 & (~wr_req_1 | ~wr_ptr);
    wr_gnt_1 = ~rst & wr_req_1 & (~wr_req_0 | wr_ptr);
    rd_gnt_0 = ~rst & rd_req_0 & (~rd_req_1 | ~rd_ptr);
    rd_gnt_1 = ~rst & rd_req_1 & (~rd_req_0 | rd_ptr);
  end

  assign req_ready_0 = wr_gnt_0 | rd_gnt_0;
  assign req_ready_1 = wr_gnt_1 | rd_gnt_1;

  always_comb begin
    ram_we         = wr_gnt_0 | wr_gnt_1;
    ram_write_addr = '0;
    ram_data       = '0;
    ram_read_addr  = '0;
    if (wr_gnt_0) begin
      ram_write_addr = req_addr_0;
      ram_data       = req_wdata_0;
    end else if (wr_gnt_1) begin
      ram_write_addr = req_addr_1;
      ram_data       = req_wdata_1;
    end
    if (rd_gnt_0)      ram_read_addr = req_addr_0;
    else if (rd_gnt_1) ram_read_addr = req_addr_1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_gnt_0)      wr_ptr <= 1'b1;
      else if (wr_gnt_1) wr_ptr <= 1'b0;
      if (rd_gnt_0)      rd_ptr <= 1'b1;
      else if (rd_gnt_1) rd_ptr <= 1'b0;
    end
  end

  // Stage 1 tag lines up with ram_q, which the RAM registers on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
    end else begin
      s1_valid <= rd_gnt_0 | rd_gnt_1;
      s1_id    <= rd_gnt_1;
    end
  end

`ifdef RAM_ARB_BYPASS_EN
  logic              s1_hit;
  logic [DATA_W-1:0] s1_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit   <= 1'b0;
      s1_wdata <= '0;
    end else begin
      s1_hit   <= ram_we & (rd_gnt_0 | rd_gnt_1) & (ram_write_addr == ram_read_addr);
      s1_wdata <= ram_data;
    end
  end

  assign rsp_data = s1_hit ? s1_wdata : ram_q;
`else
  assign rsp_data = ram_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_0 <= '0;
      rsp_rdata_1 <= '0;
    end else begin
      rsp_valid_0 <= s1_valid & ~s1_id;
      rsp_valid_1 <= s1_valid & s1_id;
      if (s1_valid & ~s1_id) rsp_rdata_0 <= rsp_data;
      if (s1_valid & s1_id)  rsp_rdata_1 <= rsp_data;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64x8 old-data RAM model.
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_0, req_valid_1, req_we_0, req_we_1;
  logic       req_ready_0, req_ready_1;
  logic [5:0] req_addr_0, req_addr_1;
  logic [7:0] req_wdata_0, req_wdata_1;
  logic       rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic       ram_we;
  logic [5:0] ram_write_addr, ram_read_addr;
  logic [7:0] ram_data, ram_q;
  logic [7:0] mem [64];

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_we_0(req_we_0), .req_we_1(req_we_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [5:0] a, input logic [7:0] d);
    req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [5:0] a, input logic [7:0] d);
    req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, 6'd0, 8'h00);
    set1(1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] w0a [2];
    logic [7:0] w0d [2];
    logic [5:0] w1a [2];
    logic [7:0] w1d [2];
    int k0, k1, win, j;
    logic [7:0] collide_exp;

    w0a[0] = 6'd1; w0d[0] = 8'h11; w0a[1] = 6'd5; w0d[1] = 8'h55;
    w1a[0] = 6'd2; w1d[0] = 8'h22; w1a[1] = 6'd6; w1d[1] = 8'h66;
`ifdef RAM_ARB_BYPASS_EN
    collide_exp = 8'h5A;
`else
    collide_exp = 8'h00;
`endif

    // Reset state: requests present but nothing may be granted
    rst = 1'b1;
    idle();
    set0(1'b1, 1'b1, 6'd3, 8'hA5);
    set1(1'b1, 1'b0, 6'd3, 8'h00);
    settle();
    chk("rst_ready0", 8'(req_ready_0), 8'h00);
    chk("rst_ready1", 8'(req_ready_1), 8'h00);
    chk("rst_ram_we", 8'(ram_we), 8'h00);
    chk("rst_rd_addr", 8'(ram_read_addr), 8'h00);
    chk("rst_rsp_valid0", 8'(rsp_valid_0), 8'h00);
    chk("rst_rdata0", rsp_rdata_0, 8'h00);
    chk("rst_rdata1", rsp_rdata_1, 8'h00);
    idle();
    step(); step();
    rst = 1'b0;
    step();

    // Write then read back through requester 0
    set0(1'b1, 1'b1, 6'd3, 8'hA5);
    settle();
    chk("wr_ready0", 8'(req_ready_0), 8'h01);
    chk("wr_ram_we", 8'(ram_we), 8'h01);
    chk("wr_addr", 8'(ram_write_addr), 8'h03);
    chk("wr_data", ram_data, 8'hA5);
    step();
    set0(1'b1, 1'b0, 6'd3, 8'h00);
    settle();
    chk("rd_ready0", 8'(req_ready_0), 8'h01);
    chk("rd_ram_we", 8'(ram_we), 8'h00);
    chk("rd_addr", 8'(ram_read_addr), 8'h03);
    step();
    idle();
    settle();
    chk("rd_n1_valid0", 8'(rsp_valid_0), 8'h00);
    step();
    chk("rd_n2_valid0", 8'(rsp_valid_0), 8'h01);
    chk("rd_n2_rdata0", rsp_rdata_0, 8'hA5);
    chk("rd_n2_valid1", 8'(rsp_valid_1), 8'h00);
    step();
    chk("rd_n3_valid0", 8'(rsp_valid_0), 8'h00);
    chk("rd_n3_hold0", rsp_rdata_0, 8'hA5);

    // Preload: addr 4 = 0x00 via req 0, addr 9 = 0x99 via req 1 (write pointer ends at 0)
    set0(1'b1, 1'b1, 6'd4, 8'h00);
    step();
    idle();
    set1(1'b1, 1'b1, 6'd9, 8'h99);
    step();
    idle();

    // Both requesters writing continuously: grants alternate 0,1,0,1
    k0 = 0; k1 = 0;
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b1, w0a[k0], w0d[k0]);
      set1(1'b1, 1'b1, w1a[k1], w1d[k1]);
      settle();
      win = i % 2;
      chk("cw_ready0", 8'(req_ready_0), (win == 0) ? 8'h01 : 8'h00);
      chk("cw_ready1", 8'(req_ready_1), (win == 1) ? 8'h01 : 8'h00);
      chk("cw_ram_we", 8'(ram_we), 8'h01);
      chk("cw_addr", 8'(ram_write_addr), (win == 0) ? 8'(w0a[k0]) : 8'(w1a[k1]));
      chk("cw_data", ram_data, (win == 0) ? w0d[k0] : w1d[k1]);
      step();
      if (win == 0) k0++; else k1++;
    end
    idle();

    // Write by req 0 and read by req 1 to different addresses in one cycle
    set0(1'b1, 1'b1, 6'd7, 8'h3C);
    set1(1'b1, 1'b0, 6'd9, 8'h00);
    settle();
    chk("wr_rd_ready0", 8'(req_ready_0), 8'h01);
    chk("wr_rd_ready1", 8'(req_ready_1), 8'h01);
    chk("wr_rd_ram_we", 8'(ram_we), 8'h01);
    chk("wr_rd_rd_addr", 8'(ram_read_addr), 8'h09);
    step();
    idle();
    step();
    chk("wr_rd_valid1", 8'(rsp_valid_1), 8'h01);
    chk("wr_rd_rdata1", rsp_rdata_1, 8'h99);
    chk("wr_rd_valid0", 8'(rsp_valid_0), 8'h00);

    // Both requesters reading continuously: responses alternate 0x11, 0x22
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        set0(1'b1, 1'b0, 6'd1, 8'h00);
        set1(1'b1, 1'b0, 6'd2, 8'h00);
      end else begin
        idle();
      end
      settle();
      if (i < 4) begin
        chk("cr_ready0", 8'(req_ready_0), (i % 2 == 0) ? 8'h01 : 8'h00);
        chk("cr_ready1", 8'(req_ready_1), (i % 2 == 1) ? 8'h01 : 8'h00);
      end
      if (i >= 2) begin
        j = i - 2;
        chk("cr_valid0", 8'(rsp_valid_0), (j % 2 == 0) ? 8'h01 : 8'h00);
        chk("cr_valid1", 8'(rsp_valid_1), (j % 2 == 1) ? 8'h01 : 8'h00);
        if (j % 2 == 0) chk("cr_rdata0", rsp_rdata_0, 8'h11);
        else            chk("cr_rdata1", rsp_rdata_1, 8'h22);
      end
      step();
    end
    idle();

    // Same-cycle write and read of the same address
    set0(1'b1, 1'b1, 6'd4, 8'h5A);
    set1(1'b1, 1'b0, 6'd4, 8'h00);
    settle();
    chk("col_ready0", 8'(req_ready_0), 8'h01);
    chk("col_ready1", 8'(req_ready_1), 8'h01);
    step();
    idle();
    step();
    chk("col_valid1", 8'(rsp_valid_1), 8'h01);
    chk("col_rdata1", rsp_rdata_1, collide_exp);

    // Reset one cycle after a read is accepted drops the response and clears pointers
    set0(1'b1, 1'b0, 6'd1, 8'h00);
    settle();
    chk("mr_ready0", 8'(req_ready_0), 8'h01);
    step();
    rst = 1'b1;
    set0(1'b1, 1'b0, 6'd1, 8'h00);
    settle();
    chk("mr_rst_ready0", 8'(req_ready_0), 8'h00);
    chk("mr_rst_valid0", 8'(rsp_valid_0), 8'h00);
    step();
    chk("mr_n2_valid0", 8'(rsp_valid_0), 8'h00);
    idle();
    step();
    chk("mr_n3_valid0", 8'(rsp_valid_0), 8'h00);
    rst = 1'b0;
    set0(1'b1, 1'b0, 6'd1, 8'h00);
    set1(1'b1, 1'b0, 6'd2, 8'h00);
    settle();
    chk("post_rst_ready0", 8'(req_ready_0), 8'h01);
    chk("post_rst_ready1", 8'(req_ready_1), 8'h00);
    step();
    idle();
    step();
    chk("post_rst_valid0", 8'(rsp_valid_0), 8'h01);
    chk("post_rst_rdata0", rsp_rdata_0, 8'h11);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter in front of the team's 64x8 simple dual-port RAM (one write port, one registered read port, old-data on same-address read/write). Each requester issues reads or writes over a valid/ready handshake. The block arbitrates the read port and the write port independently with round-robin fairness, drives the RAM pins, and returns read data to the issuing requester through a registered response stage. It sits between two client engines and the RAM instance, making the RAM a shared resource.

## Interface
- DATA_W, 8, data width; must match the RAM
- ADDR_W, 6, address width; must match the RAM
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_we_0 / req_we_1  in  1  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  ADDR_W  address
- req_wdata_0 / req_wdata_1  in  DATA_W  write data; ignored for reads
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle pulse: read data valid
- rsp_rdata_0 / rsp_rdata_1  out  DATA_W  read data
- ram_we  out  1  to RAM we
- ram_write_addr  out  ADDR_W  to RAM write_addr
- ram_data  out  DATA_W  to RAM data
- ram_read_addr  out  ADDR_W  to RAM read_addr
- ram_q  in  DATA_W  from RAM q (registered, valid one cycle after read_addr)

## Operation
- Two independent arbiters: write arbiter (requesters with valid & we) and read arbiter (valid & !we). One write and one read can be granted in the same cycle.
- Each arbiter has a 1-bit priority pointer, reset to 0 (requester 0 favoured). On contention, the pointer's requester wins. After any grant, the pointer is set to the non-granted requester.
- req_ready_i = grant_i, combinational from valid/we/pointer. Accept means valid & ready in the same cycle. Ready is 0 while rst is high.
- RAM drive:
  - ram_we = write grant.
  - ram_write_addr / ram_data = granted requester's fields, else 0.
  - ram_read_addr = granted read requester's address, else 0.
- Read pipeline:
  - Stage 1 registers the grant tag (valid, requester id).
  - Stage 2 registers ram_q into rsp_rdata_<id> and pulses rsp_valid_<id>.
- There is no response backpressure; requesters must sink responses.
- rsp_rdata_i holds its last value when rsp_valid_i is low.
- Fairness: a continuously valid requester is granted within 2 cycles.

## Timing
- Read accepted in cycle N -> rsp_valid pulse and data in cycle N+2. Full throughput: one read per cycle, back-to-back.
- Write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Same-cycle read and write to the same address: the read returns old data (see Configuration).
- Reset values: rsp_valid_* = 0, rsp_rdata_* = 0, both pointers = 0, pipeline tags cleared. Combinational RAM outputs are 0 / ram_we = 0 while rst is high.
- Reset mid-operation: in-flight reads are dropped and no response is produced. RAM contents are untouched.

## Configuration
- RAM_ARB_BYPASS_EN defined:
  - When read and write are granted in the same cycle with equal addresses, the write data and a hit flag are carried down the read pipeline.
  - The response returns the new data instead of ram_q. Latency is unchanged.
- Undefined: no bypass logic; the same-cycle collision returns old RAM contents.

## Test plan
- Reset, then requester 0 writes 0xA5 to addr 3, then reads addr 3 -> ready_0 = 1 both cycles; rsp_valid_0 pulses 2 cycles after the read with rsp_rdata_0 = 0xA5; rsp_valid_1 stays 0.
- Both requesters read continuously (addr 1 / addr 2, preloaded 0x11 / 0x22) -> grants alternate starting with requester 0; responses alternate 0x11 then 0x22, one per cycle.
- Same cycle: req 0 writes 0x3C to addr 7, req 1 reads addr 9 (holds 0x99) -> both ready = 1; rsp_rdata_1 = 0x99 at N+2; ram_we = 1 at N.
- Same cycle: req 0 writes 0x5A to addr 4 (old 0x00), req 1 reads addr 4 -> rsp_rdata_1 = 0x00 without RAM_ARB_BYPASS_EN, 0x5A with it.
- Both requesters write continuously -> ram_we held 1; write grants strictly alternate 0,1,0,1.
- Assert rst one cycle after a read is accepted -> no rsp_valid pulse; after release, the first contended grant goes to requester 0.
